// File: rtl/quad_encoder_mc.sv
// Multi-channel quadrature encoder front end: synchroniser, glitch filter, x1/x2/x4 decode,
// signed position counters with preset/index clear and windowed pulse differences.
module quad_encoder_mc #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WIN_W      = 16,
   parameter int unsigned FILT_DEPTH = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         phaseA,
   input  logic [CHANNELS-1:0]         phaseB,
   input  logic [CHANNELS-1:0]         index,
   input  logic [1:0]                  mode,
   input  logic [WIN_W-1:0]            win_len,
   input  logic [CHANNELS-1:0]         index_clr_en,
   input  logic [CHANNELS-1:0]         preset_load,
   input  logic [CNT_W-1:0]            preset_val,
   input  logic                        err_clr,
   output logic [CHANNELS*CNT_W-1:0]   pulse_count,
   output logic [CHANNELS*CNT_W-1:0]   pulse_diff,
   output logic                        diff_valid,
   output logic [CHANNELS-1:0]         err
);

   // History only holds pin-derived samples after the sync stages and the filter have refilled.
   localparam int unsigned FILL_MAX = FILT_DEPTH + 2;
   localparam int unsigned FILL_W   = $clog2(FILL_MAX + 1);

   logic [CHANNELS-1:0]   a_s1, a_s2, b_s1, b_s2;
   logic [CHANNELS-1:0]   i_s1, i_s2, i_d1, i_d2;
   logic [FILT_DEPTH-1:0] hist_a [CHANNELS];
   logic [FILT_DEPTH-1:0] hist_b [CHANNELS];
   logic [FILL_W-1:0]     fill   [CHANNELS];
   logic [1:0]            st     [CHANNELS];
   logic [CHANNELS-1:0]   primed;
   logic [CNT_W-1:0]      prev   [CHANNELS];
   logic [WIN_W-1:0]      win_cnt;

   logic [1:0]            cand_c [CHANNELS];
   logic [CHANNELS-1:0]   stable_c, upd_c, dbl_c, legal_c, step_c, down_c, idx_clr_c;
   logic                  win_term_c;

   // Forward successor in the 00->10->11->01 sequence.
   function automatic logic [1:0] fwd_next(input logic [1:0] s);
      logic [1:0] r;
      case (s)
         2'b00:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Filter acceptance, transition classification and window terminal count.
   always_comb begin
      stable_c  = '0;
      upd_c     = '0;
      dbl_c     = '0;
      legal_c   = '0;
      step_c    = '0;
      down_c    = '0;
      idx_clr_c = '0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
         cand_c[n]   = {hist_a[n][0], hist_b[n][0]};
         stable_c[n] = ((&hist_a[n]) || !(|hist_a[n])) && ((&hist_b[n]) || !(|hist_b[n]));
         upd_c[n]    = (fill[n] == FILL_W'(FILL_MAX)) && stable_c[n]
                       && (!primed[n] || (cand_c[n] != st[n]));
         dbl_c[n]    = upd_c[n] && primed[n] && ((cand_c[n] ^ st[n]) == 2'b11);
         legal_c[n]  = upd_c[n] && primed[n] && !dbl_c[n];
         down_c[n]   = (cand_c[n] != fwd_next(st[n]));
         case (mode)
            2'd0:    step_c[n] = legal_c[n];
            2'd1:    step_c[n] = legal_c[n] && (cand_c[n][1] != st[n][1]);
            2'd2:    step_c[n] = legal_c[n] && cand_c[n][1] && !st[n][1];
            default: step_c[n] = 1'b0;
         endcase
         idx_clr_c[n] = i_d1[n] && !i_d2[n] && index_clr_en[n];
      end
      win_term_c = (win_len != '0) && (win_cnt < win_len) && (win_cnt == win_len - WIN_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_s1        <= '0;
         a_s2        <= '0;
         b_s1        <= '0;
         b_s2        <= '0;
         i_s1        <= '0;
         i_s2        <= '0;
         i_d1        <= '0;
         i_d2        <= '0;
         primed      <= '0;
         err         <= '0;
         win_cnt     <= '0;
         diff_valid  <= 1'b0;
         pulse_count <= '0;
         pulse_diff  <= '0;
         for (int unsigned n = 0; n < CHANNELS; n++) begin
            hist_a[n] <= '0;
            hist_b[n] <= '0;
            fill[n]   <= '0;
            st[n]     <= '0;
            prev[n]   <= '0;
         end
      end else begin
         a_s1 <= phaseA;
         a_s2 <= a_s1;
         b_s1 <= phaseB;
         b_s2 <= b_s1;
         i_s1 <= index;
         i_s2 <= i_s1;
         i_d1 <= i_s2;
         i_d2 <= i_d1;

         diff_valid <= win_term_c;
         if ((win_len == '0) || (win_cnt >= win_len) || win_term_c)
            win_cnt <= '0;
         else
            win_cnt <= win_cnt + WIN_W'(1);

         for (int unsigned n = 0; n < CHANNELS; n++) begin
            for (int unsigned i = FILT_DEPTH - 1; i > 0; i--) begin
               hist_a[n][i] <= hist_a[n][i-1];
               hist_b[n][i] <= hist_b[n][i-1];
            end
            hist_a[n][0] <= a_s2[n];
            hist_b[n][0] <= b_s2[n];
            if (fill[n] != FILL_W'(FILL_MAX))
               fill[n] <= fill[n] + FILL_W'(1);

            if (upd_c[n]) begin
               st[n]     <= cand_c[n];
               primed[n] <= 1'b1;
            end

            if (dbl_c[n])
               err[n] <= 1'b1;
            else if (err_clr)
               err[n] <= 1'b0;

            if (preset_load[n])
               pulse_count[n*CNT_W +: CNT_W] <= preset_val;
            else if (idx_clr_c[n])
               pulse_count[n*CNT_W +: CNT_W] <= '0;
            else if (step_c[n])
               pulse_count[n*CNT_W +: CNT_W] <= down_c[n]
                  ? pulse_count[n*CNT_W +: CNT_W] - CNT_W'(1)
                  : pulse_count[n*CNT_W +: CNT_W] + CNT_W'(1);

            // A preset/clear re-bases the window reference even on a terminal-count edge.
            if (win_term_c)
               pulse_diff[n*CNT_W +: CNT_W] <= pulse_count[n*CNT_W +: CNT_W] - prev[n];
            if (preset_load[n])
               prev[n] <= preset_val;
            else if (idx_clr_c[n])
               prev[n] <= '0;
            else if (win_term_c)
               prev[n] <= pulse_count[n*CNT_W +: CNT_W];
         end
      end
   end

endmodule

// File: doc/quad_encoder_mc.md
# quad_encoder_mc

Multi-channel quadrature encoder front end for the active suspension controller: per-channel input synchroniser and glitch filter, x1/x2/x4 decoding, signed position counter with preset and index clear, and a programmable sampling window producing per-channel pulse differences (velocity) for the control loop. It sits between the encoder pins (e.g. Renishaw LM10) and the controller, replacing the single-channel fixed-window decoder.

## Interface
- CHANNELS, 2, number of independent encoder channels
- CNT_W, 32, width of each position counter and difference (two's complement)
- WIN_W, 16, width of the velocity window length
- FILT_DEPTH, 3, consecutive equal samples required to accept a new A/B level (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- phaseA  in  CHANNELS  encoder A inputs, asynchronous
- phaseB  in  CHANNELS  encoder B inputs, asynchronous
- index  in  CHANNELS  encoder index/reference inputs, asynchronous
- mode  in  2  decode mode: 0 = x4, 1 = x2, 2 = x1, 3 = counting disabled (hold)
- win_len  in  WIN_W  window length in clk cycles; 0 disables window output
- index_clr_en  in  CHANNELS  per-channel enable for clear-on-index
- preset_load  in  CHANNELS  per-channel one-cycle load strobe
- preset_val  in  CNT_W  value loaded on preset_load (shared)
- err_clr  in  1  clears all sticky error bits
- pulse_count  out  CHANNELS*CNT_W  position, channel n at [n*CNT_W +: CNT_W]
- pulse_diff  out  CHANNELS*CNT_W  count change over last window, same packing
- diff_valid  out  1  one-cycle strobe, pulse_diff updated this cycle
- err  out  CHANNELS  sticky illegal-transition flag

## Operation
- Per-channel path: 2-FF synchroniser on A, B, index; A/B then into FILT_DEPTH-deep history; filtered state {A,B} takes the new value only when all history entries are equal and differ from it.
- Priming: after reset, first accepted filtered sample loads the state without counting or error.
- Forward sequence {A,B}: 00→10→11→01→00 (+1); reverse order is −1.
- x4: every legal filtered transition steps. x2: only transitions where A changes. x1: only A rising (00→10 = +1, 01→11 = −1). mode 3: no steps; state still tracked, errors still flagged.
- Both bits change in one filtered update: no step, err[n] set, state updated. err set beats err_clr in the same cycle.
- Index: rising edge of synchronised index with index_clr_en[n]=1 clears pulse_count[n] to 0.
- Per-channel update priority: rst > preset_load > index clear > step.
- Preset or index clear also sets that channel's window reference (prev) to the loaded value.
- Window: shared counter 0..win_len−1; at terminal count, for every channel pulse_diff ← count − prev using the pre-edge count, prev ← pre-edge count; diff_valid=1 that cycle. A step on the same edge still applies to pulse_count and appears in the next window.
- win_len changed mid-window: counter restarts at 0 if current value ≥ new win_len. win_len=0: counter held at 0, no diff_valid, pulse_diff holds.
- Arithmetic modulo 2^CNT_W; count wraps 0x7F..F→0x80..0 on +1 with no flag; diff wrap-correct for |Δ| < 2^(CNT_W−1).

## Timing
- Reset values: pulse_count, pulse_diff, err, diff_valid all 0; internal prev, window counter, histories, primed flags cleared.
- Pin-to-count latency: A/B change stable before edge k → pulse_count updated at edge k+FILT_DEPTH+2.
- Index latency: pin edge before edge k → clear at edge k+3.
- preset_load at edge k → pulse_count = preset_val after edge k.
- diff_valid period = win_len cycles; first strobe win_len cycles after reset deassertion.
- Max input edge rate: one filtered transition per FILT_DEPTH+1 cycles; faster inputs are filtered, not miscounted into errors except true double changes.
- rst mid-window or mid-filter: everything cleared next edge, priming restarts.

## Test plan
- x4, FILT_DEPTH=3, 8 forward quadrature cycles (32 edges, 8 clk per edge), ch0 → pulse_count[0]=32; reverse 8 cycles → 0; ch1 idle → 0.
- Same stimulus in x2 → 16; in x1 → 8; mode 3 → 0 and err=0.
- 2-cycle glitch on A (FILT_DEPTH=3) → no count change; simultaneous A and B toggle held 10 cycles → err[0]=1, count unchanged; err_clr → err[0]=0.
- win_len=100, steady +1 step every 10 cycles → diff_valid every 100 cycles, pulse_diff=10; win_len=0 → no diff_valid.
- preset_val=0x7FFFFFFF load, then +1 step → 0x80000000 and next window diff=+1 (CNT_W=32).
- index_clr_en=1, count 50, index pulse → count 0 three cycles later; preset_load and index same cycle → preset_val wins.
